hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage single-issue datapath (IF, ID, EX, MEM, WB).
- Detects load-use hazards and freezes PC and IF/ID while inserting bubbles into ID/EX.
- Flushes the younger stages when a branch resolves taken in MEM.
- Drives the EX-stage forwarding mux selects and keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl_if.sv | 50 +++++
 rtl/hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// The pipeline (master) supplies register fields and control bits;
// the controller (slave) returns enables, flushes, forwarding selects,
// its state and the performance counters.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_wreg;
    logic             mem_reg_write;
    logic [4:0]       mem_wreg;
    logic             wb_reg_write;
    logic [4:0]       wb_wreg;
    logic             mem_branch;
    logic             mem_zero;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             flush_ex_mem;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_mem_read, ex_wreg,
               mem_reg_write, mem_wreg, wb_reg_write, wb_wreg,
               mem_branch, mem_zero,
        input  pc_write, if_id_write, id_ex_bubble, flush_if_id,
               flush_id_ex, flush_ex_mem, fwd_a, fwd_b, state,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_mem_read, ex_wreg,
               mem_reg_write, mem_wreg, wb_reg_write, wb_wreg,
               mem_branch, mem_zero,
        output pc_write, if_id_write, id_ex_bubble, flush_if_id,
               flush_id_ex, flush_ex_mem, fwd_a, fwd_b, state,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage single-issue pipeline.
// Load-use hazards freeze PC and IF/ID and bubble ID/EX for LOAD_STALL
// cycles; a taken branch resolved in MEM flushes the three younger
// stages and overrides any stall. Forwarding selects are purely
// combinational. Stall and flush events are tallied in saturating counters.
module hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic          CLK,
    input  logic          RST,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e           state_q,     state_d;
    logic [3:0]       scnt_q,      scnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             lu_s;
    logic             bt_s;
    logic             stall_s;
    logic             flush_s;
    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       SCNT_RLD = 4'(LOAD_STALL - 1);

    // Forwarding source for one operand: EX/MEM beats MEM/WB, r0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        logic [1:0] sel;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection terms.
    always_comb begin
        lu_s = bus.ex_mem_read && (bus.ex_wreg != 5'd0) &&
               ((bus.ex_wreg == bus.id_rs) || (bus.ex_wreg == bus.id_rt));
        bt_s = bus.mem_branch && bus.mem_zero;
    end

    // Next-state, stall/flush decisions and counter updates; bt > STALL > lu.
    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        stall_s     = 1'b0;
        flush_s     = 1'b0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (bt_s) begin
            flush_s = 1'b1;
            state_d = RUN;
            scnt_d  = 4'd0;
        end else if (state_q == STALL) begin
            stall_s = 1'b1;
            if (scnt_q <= 4'd1) begin
                state_d = RUN;
                scnt_d  = 4'd0;
            end else begin
                scnt_d  = scnt_q - 4'd1;
            end
        end else if (lu_s) begin
            stall_s = 1'b1;
            if (LOAD_STALL > 1) begin
                state_d = STALL;
                scnt_d  = SCNT_RLD;
            end else begin
                state_d = RUN;
                scnt_d  = 4'd0;
            end
        end else begin
            state_d = RUN;
        end

        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Operand forwarding selects, independent of controller state.
    always_comb begin
        fwd_a_s = fwd_sel(bus.ex_rs, bus.mem_reg_write, bus.mem_wreg,
                          bus.wb_reg_write, bus.wb_wreg);
        fwd_b_s = fwd_sel(bus.ex_rt, bus.mem_reg_write, bus.mem_wreg,
                          bus.wb_reg_write, bus.wb_wreg);
    end

    // Drive the pipeline controls; reset forces the benign run-through values.
    always_comb begin
        if (RST) begin
            bus.pc_write     = 1'b1;
            bus.if_id_write  = 1'b1;
            bus.id_ex_bubble = 1'b0;
            bus.flush_if_id  = 1'b0;
            bus.flush_id_ex  = 1'b0;
            bus.flush_ex_mem = 1'b0;
            bus.fwd_a        = 2'b00;
            bus.fwd_b        = 2'b00;
        end else begin
            bus.pc_write     = ~stall_s;
            bus.if_id_write  = ~stall_s;
            bus.id_ex_bubble = stall_s;
            bus.flush_if_id  = flush_s;
            bus.flush_id_ex  = flush_s;
            bus.flush_ex_mem = flush_s;
            bus.fwd_a        = fwd_a_s;
            bus.fwd_b        = fwd_b_s;
        end
        bus.state     = state_q;
        bus.stall_cnt = stall_cnt_q;
        bus.flush_cnt = flush_cnt_q;
    end

    // State, residual stall count and performance counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= RUN;
            scnt_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Three instances share one input set:
// u_ls1 (LOAD_STALL=1), u_ls3 (LOAD_STALL=3), u_c4 (LOAD_STALL=1, CNT_W=4).
// Each scenario resets all of them and checks the instance it targets.
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;

    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic       ex_mem_read, mem_reg_write, wb_reg_write, mem_branch, mem_zero;

    int checks = 0;
    int errors = 0;

    hazard_ctrl_if #(.CNT_W(16)) if1 ();
    hazard_ctrl_if #(.CNT_W(16)) if3 ();
    hazard_ctrl_if #(.CNT_W(4))  if4 ();

    assign if1.id_rs = id_rs;            assign if3.id_rs = id_rs;            assign if4.id_rs = id_rs;
    assign if1.id_rt = id_rt;            assign if3.id_rt = id_rt;            assign if4.id_rt = id_rt;
    assign if1.ex_rs = ex_rs;            assign if3.ex_rs = ex_rs;            assign if4.ex_rs = ex_rs;
    assign if1.ex_rt = ex_rt;            assign if3.ex_rt = ex_rt;            assign if4.ex_rt = ex_rt;
    assign if1.ex_mem_read = ex_mem_read; assign if3.ex_mem_read = ex_mem_read; assign if4.ex_mem_read = ex_mem_read;
    assign if1.ex_wreg = ex_wreg;        assign if3.ex_wreg = ex_wreg;        assign if4.ex_wreg = ex_wreg;
    assign if1.mem_reg_write = mem_reg_write; assign if3.mem_reg_write = mem_reg_write; assign if4.mem_reg_write = mem_reg_write;
    assign if1.mem_wreg = mem_wreg;      assign if3.mem_wreg = mem_wreg;      assign if4.mem_wreg = mem_wreg;
    assign if1.wb_reg_write = wb_reg_write; assign if3.wb_reg_write = wb_reg_write; assign if4.wb_reg_write = wb_reg_write;
    assign if1.wb_wreg = wb_wreg;        assign if3.wb_wreg = wb_wreg;        assign if4.wb_wreg = wb_wreg;
    assign if1.mem_branch = mem_branch;  assign if3.mem_branch = mem_branch;  assign if4.mem_branch = mem_branch;
    assign if1.mem_zero = mem_zero;      assign if3.mem_zero = mem_zero;      assign if4.mem_zero = mem_zero;

    hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) u_ls1 (.CLK(CLK), .RST(RST), .bus(if1));
    hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) u_ls3 (.CLK(CLK), .RST(RST), .bus(if3));
    hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4))  u_c4  (.CLK(CLK), .RST(RST), .bus(if4));

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
        ex_mem_read = 1'b0; ex_wreg = 5'd0;
        mem_reg_write = 1'b0; mem_wreg = 5'd0;
        wb_reg_write = 1'b0; wb_wreg = 5'd0;
        mem_branch = 1'b0; mem_zero = 1'b0;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Pulse reset between clock edges.
    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        #2;
        RST = 1'b0;
        #1;
    endtask

    task automatic load_use_hazard();
        ex_mem_read = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5;
    endtask

    initial begin
        clear_inputs();
        RST = 1'b1;
        // Outputs forced while reset is held, even with a hazard present.
        load_use_hazard();
        #2;
        check_eq("rst_pc_write", {31'd0, if1.pc_write}, 32'd1);
        check_eq("rst_bubble",   {31'd0, if1.id_ex_bubble}, 32'd0);
        check_eq("rst_state",    {31'd0, if1.state}, 32'd0);
        check_eq("rst_stall_cnt", {16'd0, if1.stall_cnt}, 32'd0);
        next_cycle();
        do_reset();

        // LOAD_STALL=1: single stall cycle.
        load_use_hazard();
        #1;
        check_eq("ls1_pc_write",    {31'd0, if1.pc_write}, 32'd0);
        check_eq("ls1_if_id_write", {31'd0, if1.if_id_write}, 32'd0);
        check_eq("ls1_bubble",      {31'd0, if1.id_ex_bubble}, 32'd1);
        next_cycle();
        clear_inputs();
        #1;
        check_eq("ls1_pc_write_after", {31'd0, if1.pc_write}, 32'd1);
        check_eq("ls1_stall_cnt",      {16'd0, if1.stall_cnt}, 32'd1);

        // LOAD_STALL=3: three stall cycles, STALL in cycles 2 and 3.
        next_cycle();
        do_reset();
        load_use_hazard();
        #1;
        check_eq("ls3_c1_pc_write", {31'd0, if3.pc_write}, 32'd0);
        check_eq("ls3_c1_state",    {31'd0, if3.state}, 32'd0);
        next_cycle();
        clear_inputs();
        for (int c = 2; c <= 3; c++) begin
            #1;
            check_eq($sformatf("ls3_c%0d_pc_write", c), {31'd0, if3.pc_write}, 32'd0);
            check_eq($sformatf("ls3_c%0d_bubble", c),   {31'd0, if3.id_ex_bubble}, 32'd1);
            check_eq($sformatf("ls3_c%0d_state", c),    {31'd0, if3.state}, 32'd1);
            next_cycle();
        end
        #1;
        check_eq("ls3_end_state",     {31'd0, if3.state}, 32'd0);
        check_eq("ls3_end_pc_write",  {31'd0, if3.pc_write}, 32'd1);
        check_eq("ls3_end_stall_cnt", {16'd0, if3.stall_cnt}, 32'd3);

        // Taken branch during second stall cycle overrides the stall.
        next_cycle();
        do_reset();
        load_use_hazard();
        next_cycle();
        clear_inputs();
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1;
        check_eq("bt_flush_if_id",  {31'd0, if3.flush_if_id}, 32'd1);
        check_eq("bt_flush_id_ex",  {31'd0, if3.flush_id_ex}, 32'd1);
        check_eq("bt_flush_ex_mem", {31'd0, if3.flush_ex_mem}, 32'd1);
        check_eq("bt_pc_write",     {31'd0, if3.pc_write}, 32'd1);
        check_eq("bt_bubble",       {31'd0, if3.id_ex_bubble}, 32'd0);
        next_cycle();
        clear_inputs();
        #1;
        check_eq("bt_next_state", {31'd0, if3.state}, 32'd0);
        check_eq("bt_flush_cnt",  {16'd0, if3.flush_cnt}, 32'd1);
        check_eq("bt_stall_cnt",  {16'd0, if3.stall_cnt}, 32'd1);
        check_eq("bt_next_flush", {31'd0, if3.flush_if_id}, 32'd0);

        // Forwarding priority and register-zero exclusion.
        ex_rs = 5'd7; mem_reg_write = 1'b1; mem_wreg = 5'd7;
        wb_reg_write = 1'b1; wb_wreg = 5'd7;
        #1;
        check_eq("fwd_a_exmem", {30'd0, if1.fwd_a}, 32'd2);
        mem_reg_write = 1'b0;
        #1;
        check_eq("fwd_a_memwb", {30'd0, if1.fwd_a}, 32'd1);
        ex_rs = 5'd0; wb_wreg = 5'd0;
        #1;
        check_eq("fwd_a_none", {30'd0, if1.fwd_a}, 32'd0);
        ex_rt = 5'd3; wb_wreg = 5'd3; mem_reg_write = 1'b1; mem_wreg = 5'd4;
        #1;
        check_eq("fwd_b_memwb", {30'd0, if1.fwd_b}, 32'd1);
        mem_wreg = 5'd3;
        #1;
        check_eq("fwd_b_exmem", {30'd0, if1.fwd_b}, 32'd2);
        ex_rt = 5'd0; mem_wreg = 5'd0; wb_wreg = 5'd0;
        #1;
        check_eq("fwd_b_r0", {30'd0, if1.fwd_b}, 32'd0);
        clear_inputs();

        // Load into r0 never stalls.
        ex_mem_read = 1'b1; ex_wreg = 5'd0; id_rt = 5'd0; id_rs = 5'd0;
        #1;
        check_eq("r0_no_stall", {31'd0, if1.pc_write}, 32'd1);

        // Saturation: 20 stall cycles on a 4-bit counter.
        next_cycle();
        do_reset();
        ex_mem_read = 1'b1; ex_wreg = 5'd9; id_rt = 5'd9;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
        end
        check_eq("sat_pc_write",   {31'd0, if4.pc_write}, 32'd0);
        check_eq("sat_c4_cnt",     {28'd0, if4.stall_cnt}, 32'd15);
        check_eq("sat_c16_cnt",    {16'd0, if1.stall_cnt}, 32'd20);
        clear_inputs();

        // Asynchronous reset mid-stall with two stall cycles pending.
        next_cycle();
        do_reset();
        load_use_hazard();
        next_cycle();
        clear_inputs();
        #1;
        check_eq("ar_pre_state", {31'd0, if3.state}, 32'd1);
        #1;
        RST = 1'b1;
        #1;
        check_eq("ar_state",     {31'd0, if3.state}, 32'd0);
        check_eq("ar_stall_cnt", {16'd0, if3.stall_cnt}, 32'd0);
        check_eq("ar_flush_cnt", {16'd0, if3.flush_cnt}, 32'd0);
        check_eq("ar_pc_write",  {31'd0, if3.pc_write}, 32'd1);
        #1;
        RST = 1'b0;
        next_cycle();
        check_eq("ar_post_pc_write", {31'd0, if3.pc_write}, 32'd1);
        check_eq("ar_post_state",    {31'd0, if3.state}, 32'd0);
        check_eq("ar_post_stall_cnt", {16'd0, if3.stall_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
